// File: rtl/vga_frame_decoder.sv
// Receive-side VGA decoder: recovers active-area coordinates from sync/blank/RGB,
// checks line and frame geometry, and captures the colour at a probe coordinate.
module vga_frame_decoder #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iPixEn,
    input  logic        iHsync,
    input  logic        iVsync,
    input  logic        iBlank_n,
    input  logic [7:0]  iRed,
    input  logic [7:0]  iGreen,
    input  logic [7:0]  iBlue,
    input  logic [10:0] iProbeX,
    input  logic [10:0] iProbeY,
    input  logic        iClrErr,
    output logic [10:0] oHCoordinate,
    output logic [10:0] oVCoordinate,
    output logic [23:0] oPixel,
    output logic        oPixValid,
    output logic        oFrameStart,
    output logic        oLocked,
    output logic        oLineErr,
    output logic        oFrameErr,
    output logic [23:0] oProbeColor,
    output logic        oProbeValid
);

    typedef enum logic [1:0] {UNLOCKED, SYNCED, LOCKED} state_t;

    localparam logic [10:0] CNT_MAX = 11'd2047;
    localparam logic [10:0] H_EXP   = 11'(H_ACTIVE);
    localparam logic [10:0] V_EXP   = 11'(V_ACTIVE);

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == CNT_MAX) ? v : v + 11'd1;
    endfunction

    state_t      state_q, state_d;
    logic        hs_q, vs_q;
    logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic        lerr_frame_q, lerr_frame_d;
    logic [10:0] hco_q, vco_q;
    logic [23:0] pix_q, prbcol_q;
    logic        pixvld_q, fstart_q, lerr_q, ferr_q, prbvld_q;

    logic        hs, vs, hs_edge, vs_edge, active;
    logic [10:0] hcnt_line, vcnt_line;
    logic        line_closed, line_err, frame_chk, frame_bad, frame_err, probe_hit;
    logic [23:0] color;

    // Internal syncs are asserted-high regardless of the incoming polarity.
    assign hs    = iHsync ^ ~SYNC_POL;
    assign vs    = iVsync ^ ~SYNC_POL;
    assign color = {iRed, iGreen, iBlue};

    assign hs_edge = iPixEn & hs & ~hs_q;
    assign vs_edge = iPixEn & vs & ~vs_q;
    assign active  = iPixEn & iBlank_n;

    // A pixel sampled with the hs edge still belongs to the line being closed.
    assign hcnt_line   = active ? sat_inc(hcnt_q) : hcnt_q;
    assign line_closed = hs_edge && (hcnt_line != 11'd0);
    assign line_err    = line_closed && (hcnt_line != H_EXP);
    assign vcnt_line   = line_closed ? sat_inc(vcnt_q) : vcnt_q;

    assign frame_chk = vs_edge && (state_q != UNLOCKED);
    assign frame_bad = (vcnt_line != V_EXP) || lerr_frame_q || line_err;
    assign frame_err = frame_chk && frame_bad;
    assign probe_hit = active && (hcnt_q == iProbeX) && (vcnt_q == iProbeY);

    always_comb begin
        state_d      = state_q;
        hcnt_d       = hs_edge ? 11'd0 : hcnt_line;
        vcnt_d       = vs_edge ? 11'd0 : vcnt_line;
        lerr_frame_d = vs_edge ? 1'b0 : (lerr_frame_q | line_err);
        case (state_q)
            UNLOCKED: if (vs_edge) state_d = SYNCED;
            SYNCED:   if (frame_chk && !frame_bad) state_d = LOCKED;
            LOCKED:   if (line_err || frame_err) state_d = SYNCED;
            default:  state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= UNLOCKED;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            lerr_frame_q <= 1'b0;
            hco_q        <= '0;
            vco_q        <= '0;
            pix_q        <= '0;
            pixvld_q     <= 1'b0;
            fstart_q     <= 1'b0;
            lerr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            prbcol_q     <= '0;
            prbvld_q     <= 1'b0;
        end else begin
            pixvld_q <= active;
            fstart_q <= vs_edge;
            prbvld_q <= probe_hit;
            if (iPixEn) begin
                hs_q         <= hs;
                vs_q         <= vs;
                hcnt_q       <= hcnt_d;
                vcnt_q       <= vcnt_d;
                lerr_frame_q <= lerr_frame_d;
                // A same-cycle error event overrides the clear.
                lerr_q       <= line_err  | (lerr_q & ~iClrErr);
                ferr_q       <= frame_err | (ferr_q & ~iClrErr);
            end
            if (active) begin
                hco_q <= hcnt_q;
                vco_q <= vcnt_q;
                pix_q <= color;
            end
            if (probe_hit) prbcol_q <= color;
        end
    end

    assign oHCoordinate = hco_q;
    assign oVCoordinate = vco_q;
    assign oPixel       = pix_q;
    assign oPixValid    = pixvld_q;
    assign oFrameStart  = fstart_q;
    assign oLocked      = (state_q == LOCKED);
    assign oLineErr     = lerr_q;
    assign oFrameErr    = ferr_q;
    assign oProbeColor  = prbcol_q;
    assign oProbeValid  = prbvld_q;

endmodule
